// File: rtl/cycle_sequencer_pkg.sv
// Shared phase codes, FSM encoding and subcycle helpers
// for the instruction cycle sequencer.
package cycle_sequencer_pkg;

  localparam int unsigned NUM_SUBCYCLES = 8;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STARTUP,
    ST_RUN,
    ST_HOLD
  } state_e;

  function automatic logic [NUM_SUBCYCLES-1:0] phase_onehot(
    input logic [2:0] ph
  );
    phase_onehot     = '0;
    phase_onehot[ph] = 1'b1;
  endfunction

endpackage

// File: rtl/cycle_edge_detect.sv
// clk2 rise detection and sticky clk1/clk2 overlap flag,
// both sampled as data on the system clock.
module cycle_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk1_i,
  input  logic clk2_i,
  output logic rise_o,
  output logic overlap_err_o
);

  logic clk2_q;
  logic overlap_q;
  logic overlap_d;

  assign overlap_d = overlap_q | (clk1_i & clk2_i);

  // clk2_q resets high so a clk2 already high at release is no rise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk2_q    <= 1'b1;
      overlap_q <= 1'b0;
    end else begin
      clk2_q    <= clk2_i;
      overlap_q <= overlap_d;
    end
  end

  assign rise_o        = clk2_i & ~clk2_q;
  assign overlap_err_o = overlap_q;

endmodule

// File: rtl/cycle_sequencer.sv
// Eight-subcycle instruction cycle sequencer stepped by clk2 rises.
// Optional X3 hold on stop: define CYCLE_SEQUENCER_STOP_EN.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int unsigned STARTUP_PHASES = 2
) (
  input  logic       sysclk,
  input  logic       poc,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       stop,
  output logic [2:0] phase,
  output logic [7:0] phase_oh,
  output logic       sync,
  output logic       stop_ack,
  output logic       overlap_err
);

  localparam logic [3:0] CNT_INIT = 4'(STARTUP_PHASES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] oh_q, oh_d;
  logic       sync_q, sync_d;
  logic       ack_q, ack_d;
  logic       rise;
  logic       stop_en;
  logic       active;

`ifdef CYCLE_SEQUENCER_STOP_EN
  assign stop_en = stop;
`else
  logic unused_stop;
  assign unused_stop = stop;
  assign stop_en     = 1'b0;
`endif

  cycle_edge_detect u_edge (
    .clk_i         (sysclk),
    .rst_i         (poc),
    .clk1_i        (clk1),
    .clk2_i        (clk2),
    .rise_o        (rise),
    .overlap_err_o (overlap_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_STARTUP;
        cnt_d   = CNT_INIT;
      end
      ST_STARTUP: begin
        if (rise) begin
          if (cnt_q == 4'd0) begin
            state_d = ST_RUN;
            phase_d = PH_X3;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_RUN: begin
        if (rise) begin
          if (phase_q == PH_X3 && stop_en) begin
            state_d = ST_HOLD;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      ST_HOLD: begin
        if (rise && !stop_en) begin
          state_d = ST_RUN;
          phase_d = PH_A1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the next state so they change on the same edge
  always_comb begin
    active = (state_d == ST_RUN) || (state_d == ST_HOLD);
    oh_d   = active ? phase_onehot(phase_d) : 8'h00;
    sync_d = active && (phase_d == PH_X3);
    ack_d  = (state_d == ST_HOLD);
  end

  always_ff @(posedge sysclk) begin
    if (poc) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_INIT;
      phase_q <= PH_A1;
      oh_q    <= 8'h00;
      sync_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      oh_q    <= oh_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
    end
  end

  assign phase    = phase_q;
  assign phase_oh = oh_q;
  assign sync     = sync_q;
  assign stop_ack = ack_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer with an in-bench
// two-phase clock generator driven on sysclk negedges.
module tb_cycle_sequencer;

  logic       sysclk = 1'b0;
  logic       poc;
  logic       clk1;
  logic       clk2;
  logic       stop;
  logic [2:0] phase;
  logic [7:0] phase_oh;
  logic       sync;
  logic       stop_ack;
  logic       overlap_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #10 sysclk = ~sysclk;

  cycle_sequencer #(
    .STARTUP_PHASES (2)
  ) dut (
    .sysclk      (sysclk),
    .poc         (poc),
    .clk1        (clk1),
    .clk2        (clk2),
    .stop        (stop),
    .phase       (phase),
    .phase_oh    (phase_oh),
    .sync        (sync),
    .stop_ack    (stop_ack),
    .overlap_err (overlap_err)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(
    input string      tag,
    input logic [2:0] ph,
    input logic [7:0] oh,
    input logic       sy,
    input logic       ack
  );
    chk($sformatf("%s_phase", tag), 32'(phase), 32'(ph));
    chk($sformatf("%s_oh", tag), 32'(phase_oh), 32'(oh));
    chk($sformatf("%s_sync", tag), 32'(sync), 32'(sy));
    chk($sformatf("%s_ack", tag), 32'(stop_ack), 32'(ack));
  endtask

  // One clockgen subcycle: clk1 pulse, then clk2 pulse.
  // stop takes s_pre between rises and s_rise at the clk2 rise.
  task automatic step(input logic s_pre, input logic s_rise);
    stop = s_pre;
    clk1 = 1'b1;
    @(negedge sysclk);
    clk1 = 1'b0;
    @(negedge sysclk);
    clk2 = 1'b1;
    stop = s_rise;
    @(negedge sysclk);
    clk2 = 1'b0;
    @(negedge sysclk);
  endtask

  initial begin
    int syncs;
    int e;
    poc  = 1'b1;
    clk1 = 1'b0;
    clk2 = 1'b1;
    stop = 1'b0;
    repeat (3) @(negedge sysclk);
    check_out("reset", 3'd0, 8'h00, 1'b0, 1'b0);
    chk("reset_ovl", 32'(overlap_err), 32'd0);

    poc = 1'b0;
    @(negedge sysclk);
    clk2 = 1'b0;
    @(negedge sysclk);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_out("startup", 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_out("first_x3", 3'd7, 8'h80, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_out("first_a1", 3'd0, 8'h01, 1'b0, 1'b0);

    syncs = 0;
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, 1'b0);
      e = i % 8;
      check_out($sformatf("run%0d", i), 3'(e),
                8'(1 << e), e == 7, 1'b0);
      syncs += int'(sync);
    end
    chk("sync_count", 32'(syncs), 32'd3);

    repeat (30) @(negedge sysclk);
    chk("freeze_low", 32'(phase), 32'd0);
    clk2 = 1'b1;
    repeat (30) @(negedge sysclk);
    chk("freeze_high", 32'(phase), 32'd1);
    clk2 = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("freeze_ovl", 32'(overlap_err), 32'd0);

    repeat (6) step(1'b0, 1'b0);
    check_out("pre_stop", 3'd7, 8'h80, 1'b1, 1'b0);
`ifdef CYCLE_SEQUENCER_STOP_EN
    step(1'b1, 1'b1);
    check_out("hold_enter", 3'd7, 8'h80, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1);
      check_out($sformatf("hold%0d", i), 3'd7, 8'h80, 1'b1, 1'b1);
    end
    step(1'b1, 1'b0);
    check_out("hold_exit", 3'd0, 8'h01, 1'b0, 1'b0);
`else
    step(1'b1, 1'b1);
    check_out("stop_off", 3'd0, 8'h01, 1'b0, 1'b0);
`endif
    stop = 1'b0;

    repeat (3) step(1'b0, 1'b0);
    chk("m1_reach", 32'(phase), 32'd3);
    step(1'b1, 1'b1);
    check_out("stop_m1", 3'd4, 8'h10, 1'b0, 1'b0);
    for (int i = 5; i <= 8; i++) begin
      step(1'b0, 1'b0);
      e = i % 8;
      check_out($sformatf("post_m1_%0d", i), 3'(e),
                8'(1 << e), e == 7, 1'b0);
    end

    clk1 = 1'b1;
    clk2 = 1'b1;
    @(negedge sysclk);
    clk1 = 1'b0;
    @(negedge sysclk);
    clk2 = 1'b0;
    @(negedge sysclk);
    chk("ovl_set", 32'(overlap_err), 32'd1);
    chk("ovl_phase", 32'(phase), 32'd1);
    repeat (3) step(1'b0, 1'b0);
    chk("ovl_sticky", 32'(overlap_err), 32'd1);
    check_out("ovl_run", 3'd4, 8'h10, 1'b0, 1'b0);

    poc = 1'b1;
    @(negedge sysclk);
    check_out("poc_m2", 3'd0, 8'h00, 1'b0, 1'b0);
    chk("poc_ovl", 32'(overlap_err), 32'd0);
    poc = 1'b0;
    @(negedge sysclk);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_out("restart_idle", 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_out("restart_x3", 3'd7, 8'h80, 1'b1, 1'b0);

`ifdef CYCLE_SEQUENCER_STOP_EN
    step(1'b1, 1'b1);
    check_out("hold2", 3'd7, 8'h80, 1'b1, 1'b1);
`endif
    poc = 1'b1;
    @(negedge sysclk);
    check_out("poc_x3", 3'd0, 8'h00, 1'b0, 1'b0);
    poc  = 1'b0;
    stop = 1'b0;
    @(negedge sysclk);
    repeat (3) step(1'b0, 1'b0);
    check_out("restart2", 3'd7, 8'h80, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter STARTUP_PHASES, default 2, number of clk2 rising edges ignored after poc release before sequencing begins (range 0..15).
REQ-002 sysclk  input  1  system clock; the single clock for all state, shared with clockgen.
REQ-003 poc  input  1  power-on clear; synchronous, active-high reset.
REQ-004 clk1  input  1  phase-1 clock level from clockgen; sampled as data on sysclk.
REQ-005 clk2  input  1  phase-2 clock level from clockgen; sampled as data on sysclk.
REQ-006 stop  input  1  request to hold the instruction cycle at X3.
REQ-007 phase  output  3  current subcycle code: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
REQ-008 phase_oh  output  8  one-hot subcycle strobe; bit n set when phase==n; all zero in IDLE/STARTUP.
REQ-009 sync  output  1  high exactly while phase==X3 and sequencer running or stopped.
REQ-010 stop_ack  output  1  high while sequencer is held at X3 by stop.
REQ-011 overlap_err  output  1  sticky flag: clk1 and clk2 were sampled high together.

Function
REQ-012 The block SHALL register clk2 each sysclk into clk2_q; a clk2 rise SHALL be a sysclk edge with clk2==1 and clk2_q==0.
REQ-013 States SHALL be IDLE, STARTUP, RUN, HOLD; all outputs registered and updated on the same sysclk edge as the state change (latency 0 cycles after the detecting edge).
REQ-014 IDLE: entered from reset; next edge after poc low moves to STARTUP with counter = STARTUP_PHASES.
REQ-015 STARTUP: each clk2 rise decrements the counter; on a clk2 rise with counter==0 the block SHALL enter RUN with phase=X3, sync=1.
REQ-016 RUN: each clk2 rise advances phase modulo 8 (X3 wraps to A1); no other event changes phase.
REQ-017 A clk2 rise while phase==X3 and stop==1 SHALL enter HOLD instead of A1; phase stays X3, sync stays 1, stop_ack=1.
REQ-018 HOLD: a clk2 rise with stop==0 SHALL go to RUN with phase=A1, stop_ack=0; stop changes between clk2 rises are ignored.
REQ-019 stop sampled at any phase other than X3 SHALL have no effect.
REQ-020 overlap_err SHALL set on any edge with clk1==1 and clk2==1, hold until poc; it SHALL NOT alter sequencing.
REQ-021 clk2 held constant SHALL freeze phase indefinitely without error.

Reset
REQ-022 On any sysclk edge with poc==1: state=IDLE, phase=0, phase_oh=0, sync=0, stop_ack=0, overlap_err=0, clk2_q=1 (a clk2 already high at release is not a rise), counter=STARTUP_PHASES.
REQ-023 poc asserted mid-cycle or during HOLD SHALL take effect on that same edge, overriding every other event.

Configuration
REQ-024 Macro CYCLE_SEQUENCER_STOP_EN: when defined, REQ-017..REQ-019 apply; when undefined, stop is ignored, HOLD is unreachable, stop_ack is constant 0.

Structure
REQ-025 A shared package SHALL hold the phase code constants (A1..X3), the state encoding, and the subcycle count 8.
REQ-026 One sub-module, cycle_edge_detect (clk2 rise + overlap detection), is natural; the FSM stays in cycle_sequencer.

Verification
REQ-027 Bench with clockgen, SYSCLK_TCY=20, STARTUP_PHASES=2: after poc release, 2 clk2 rises ignored, 3rd rise -> phase=7, sync=1; next rise -> phase=0, phase_oh=8'h01.
REQ-028 Free run 24 clk2 rises from A1: phase sequence 0..7 three times, sync high exactly 3 subcycles, phase_oh always one-hot.
REQ-029 With macro: stop=1 during X3 -> at next rise phase=7, stop_ack=1 for 5 rises; stop=0 -> next rise phase=0, stop_ack=0. Without macro: same stimulus -> phase=0, stop_ack=0.
REQ-030 stop=1 pulsed during phase M1 and dropped before X3 -> no hold, sequence unchanged.
REQ-031 Force clk1=clk2=1 for one sysclk -> overlap_err=1 and stays 1; phase progression unchanged; poc -> overlap_err=0.
REQ-032 poc asserted at phase=4 and while in HOLD -> next edge all outputs zero, state IDLE; STARTUP restarts after release.
